// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions: format codes, opcode boundaries, opcode-to-format
// classification and register-field slot positions counted from the MSB.
package cpu_isa_pkg;

    localparam int OPC_W_ISA = 5;

    typedef enum logic [2:0] {
        FMT_MEM  = 3'd0,
        FMT_R    = 3'd1,
        FMT_IMM  = 3'd2,
        FMT_UN   = 3'd3,
        FMT_BR   = 3'd4,
        FMT_J    = 3'd5,
        FMT_IO   = 3'd6,
        FMT_MISC = 3'd7
    } fmt_e;

    // Last opcode of each contiguous format range
    localparam logic [OPC_W_ISA-1:0] OP_ST   = 5'b00010;
    localparam logic [OPC_W_ISA-1:0] OP_ALUZ = 5'b01011;
    localparam logic [OPC_W_ISA-1:0] OP_ORI  = 5'b01110;
    localparam logic [OPC_W_ISA-1:0] OP_NOT  = 5'b10010;
    localparam logic [OPC_W_ISA-1:0] OP_BR   = 5'b10011;
    localparam logic [OPC_W_ISA-1:0] OP_JAL  = 5'b10101;
    localparam logic [OPC_W_ISA-1:0] OP_MFLO = 5'b11001;
    localparam logic [OPC_W_ISA-1:0] OP_HALT = 5'b11011;

    // Register fields sit in consecutive REG_W slots below the opcode
    localparam int RA_SLOT = 1;
    localparam int RB_SLOT = 2;
    localparam int RC_SLOT = 3;

    function automatic fmt_e opc_fmt(input logic [OPC_W_ISA-1:0] op);
        fmt_e f;
        if (op <= OP_ST)        f = FMT_MEM;
        else if (op <= OP_ALUZ) f = FMT_R;
        else if (op <= OP_ORI)  f = FMT_IMM;
        else if (op <= OP_NOT)  f = FMT_UN;
        else if (op == OP_BR)   f = FMT_BR;
        else if (op <= OP_JAL)  f = FMT_J;
        else if (op <= OP_MFLO) f = FMT_IO;
        else                    f = FMT_MISC;
        return f;
    endfunction

    function automatic logic opc_illegal(input logic [OPC_W_ISA-1:0] op);
        return (op > OP_HALT);
    endfunction

endpackage

// File: rtl/ir_fifo.sv
// Prefetch queue: DEPTH-entry circular buffer with valid/ready push side,
// pop on request, and a synchronous flush that empties it.
module ir_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       Clock,
    input  logic                       Clear,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_instr,
    input  logic                       pop_req,
    output logic [DATA_W-1:0]          head_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  head_ptr;
    logic [PTR_W-1:0]  tail_ptr;
    logic              push;
    logic              pop;

    assign in_ready  = (count != CNT_W'(DEPTH));
    assign push      = in_valid && in_ready && !flush;
    assign pop       = pop_req && (count != '0) && !flush;
    assign head_data = mem[head_ptr];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push) tail_ptr <= tail_ptr + 1'b1;
            if (pop)  head_ptr <= head_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (push) mem[tail_ptr] <= in_instr;
    end

endmodule

// File: rtl/ir_prefetch_decode.sv
// Instruction register fed from the prefetch queue, with combinational
// field decode that zeroes fields unused by the instruction's format.
module ir_prefetch_decode
    import cpu_isa_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OPC_W  = 5,
    parameter int REG_W  = 4,
    parameter int DEPTH  = 4
) (
    input  logic                       Clock,
    input  logic                       Clear,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_instr,
    input  logic                       IRin,
    output logic                       ir_valid,
    output logic [DATA_W-1:0]          IR,
    output logic [OPC_W-1:0]           Opcode,
    output logic [REG_W-1:0]           Ra,
    output logic [REG_W-1:0]           Rb,
    output logic [REG_W-1:0]           Rc,
    output logic [DATA_W-1:0]          C,
    output logic [REG_W-1:0]           C2,
    output logic [DATA_W-OPC_W-REG_W-1:0] Jaddr,
    output logic [2:0]                 fmt,
    output logic                       illegal,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW    = DATA_W - OPC_W - 2*REG_W;
    localparam int JW    = DATA_W - OPC_W - REG_W;
    localparam int RA_HI = DATA_W - OPC_W - (RA_SLOT-1)*REG_W - 1;
    localparam int RB_HI = DATA_W - OPC_W - (RB_SLOT-1)*REG_W - 1;
    localparam int RC_HI = DATA_W - OPC_W - (RC_SLOT-1)*REG_W - 1;

    logic [DATA_W-1:0] head_data;
    logic [DATA_W-1:0] ir_p1;
    logic              vld_p1;
    logic [OPC_W-1:0]  op_f;
    fmt_e              dfmt;
    logic              dill;

    function automatic logic signed [DATA_W-1:0] sext_imm(input logic [CW-1:0] f);
        return {{(DATA_W-CW){f[CW-1]}}, f};
    endfunction

    ir_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .Clock     (Clock),
        .Clear     (Clear),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .pop_req   (IRin),
        .head_data (head_data),
        .count     (count)
    );

    // Stage p1: instruction register; an empty-queue IRin drops valid but keeps IR
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            ir_p1  <= '0;
            vld_p1 <= 1'b0;
        end else if (flush) begin
            ir_p1  <= '0;
            vld_p1 <= 1'b0;
        end else if (IRin) begin
            if (count != '0) begin
                ir_p1  <= head_data;
                vld_p1 <= 1'b1;
            end else begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign IR       = ir_p1;
    assign ir_valid = vld_p1;
    assign op_f     = ir_p1[DATA_W-1 -: OPC_W];
    assign dfmt     = opc_fmt(OPC_W_ISA'(op_f));
    assign dill     = opc_illegal(OPC_W_ISA'(op_f));

    always_comb begin
        Opcode  = '0;
        Ra      = '0;
        Rb      = '0;
        Rc      = '0;
        C       = '0;
        C2      = '0;
        Jaddr   = '0;
        fmt     = '0;
        illegal = 1'b0;
        if (vld_p1) begin
            Opcode  = op_f;
            fmt     = dfmt;
            illegal = dill;
            case (dfmt)
                FMT_MEM, FMT_IMM: begin
                    Ra = ir_p1[RA_HI -: REG_W];
                    Rb = ir_p1[RB_HI -: REG_W];
                    C  = sext_imm(ir_p1[CW-1:0]);
                end
                FMT_R: begin
                    Ra = ir_p1[RA_HI -: REG_W];
                    Rb = ir_p1[RB_HI -: REG_W];
                    Rc = ir_p1[RC_HI -: REG_W];
                end
                FMT_UN: begin
                    Ra = ir_p1[RA_HI -: REG_W];
                    Rb = ir_p1[RB_HI -: REG_W];
                end
                FMT_BR: begin
                    Ra = ir_p1[RA_HI -: REG_W];
                    C2 = ir_p1[RB_HI -: REG_W];
                    C  = sext_imm(ir_p1[CW-1:0]);
                end
                FMT_J: begin
                    Ra    = ir_p1[RA_HI -: REG_W];
                    Jaddr = ir_p1[JW-1:0];
                end
                FMT_IO: begin
                    Ra = ir_p1[RA_HI -: REG_W];
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ir_prefetch_decode.sv
// Bench for ir_prefetch_decode: decode vector table, queue corner sequences,
// and random traffic against a queue-based reference model.
module tb_ir_prefetch_decode;

    localparam int DEPTH = 4;

    logic        Clock = 1'b0;
    logic        Clear = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic        IRin = 1'b0;
    logic        ir_valid;
    logic [31:0] IR;
    logic [4:0]  Opcode;
    logic [3:0]  Ra, Rb, Rc, C2;
    logic [31:0] C;
    logic [22:0] Jaddr;
    logic [2:0]  fmt;
    logic        illegal;
    logic [2:0]  count;

    ir_prefetch_decode #(.DATA_W(32), .OPC_W(5), .REG_W(4), .DEPTH(DEPTH)) dut (
        .Clock(Clock), .Clear(Clear), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready), .in_instr(in_instr), .IRin(IRin), .ir_valid(ir_valid),
        .IR(IR), .Opcode(Opcode), .Ra(Ra), .Rb(Rb), .Rc(Rc), .C(C), .C2(C2),
        .Jaddr(Jaddr), .fmt(fmt), .illegal(illegal), .count(count)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [4:0]  opc;
        logic [3:0]  ra, rb, rc, c2;
        logic [31:0] c;
        logic [22:0] jaddr;
        logic [2:0]  fmt;
        logic        ill;
    } dec_t;

    typedef struct packed {
        logic [31:0] instr;
        dec_t        exp;
    } vec_t;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] mq[$];
    logic [31:0] m_ir = '0;
    logic        m_vld = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference decode from the opcode map, using shifts and integer ranges
    function automatic dec_t ref_decode(input logic [31:0] w, input logic v);
        dec_t d;
        int unsigned op, ra, rb, rc, imm, j;
        logic [31:0] cs;
        d = '0;
        if (!v) return d;
        op  = w >> 27;
        ra  = (w >> 23) & 32'hF;
        rb  = (w >> 19) & 32'hF;
        rc  = (w >> 15) & 32'hF;
        imm = w & 32'h7FFFF;
        j   = w & 32'h7FFFFF;
        cs  = (imm >= 32'h40000) ? (imm - 32'h80000) : imm;
        d.opc = op[4:0];
        if (op <= 2)       begin d.fmt = 0; d.ra = ra[3:0]; d.rb = rb[3:0]; d.c = cs; end
        else if (op <= 11) begin d.fmt = 1; d.ra = ra[3:0]; d.rb = rb[3:0]; d.rc = rc[3:0]; end
        else if (op <= 14) begin d.fmt = 2; d.ra = ra[3:0]; d.rb = rb[3:0]; d.c = cs; end
        else if (op <= 18) begin d.fmt = 3; d.ra = ra[3:0]; d.rb = rb[3:0]; end
        else if (op == 19) begin d.fmt = 4; d.ra = ra[3:0]; d.c2 = rb[3:0]; d.c = cs; end
        else if (op <= 21) begin d.fmt = 5; d.ra = ra[3:0]; d.jaddr = j[22:0]; end
        else if (op <= 25) begin d.fmt = 6; d.ra = ra[3:0]; end
        else               begin d.fmt = 7; d.ill = (op >= 28); end
        return d;
    endfunction

    task automatic check_dec(input string tag, input dec_t e);
        check({tag, ".Opcode"},  64'(Opcode),  64'(e.opc));
        check({tag, ".Ra"},      64'(Ra),      64'(e.ra));
        check({tag, ".Rb"},      64'(Rb),      64'(e.rb));
        check({tag, ".Rc"},      64'(Rc),      64'(e.rc));
        check({tag, ".C"},       64'(C),       64'(e.c));
        check({tag, ".C2"},      64'(C2),      64'(e.c2));
        check({tag, ".Jaddr"},   64'(Jaddr),   64'(e.jaddr));
        check({tag, ".fmt"},     64'(fmt),     64'(e.fmt));
        check({tag, ".illegal"}, 64'(illegal), 64'(e.ill));
    endtask

    task automatic check_model(input string tag);
        check({tag, ".count"},    64'(count),    64'(mq.size()));
        check({tag, ".in_ready"}, 64'(in_ready), 64'(mq.size() < DEPTH));
        check({tag, ".ir_valid"}, 64'(ir_valid), 64'(m_vld));
        check({tag, ".IR"},       64'(IR),       64'(m_ir));
        check_dec(tag, ref_decode(m_ir, m_vld));
    endtask

    task automatic model_update(input logic v, input logic [31:0] w, input logic ir, input logic f);
        int sz;
        sz = mq.size();
        if (f) begin
            mq.delete();
            m_ir  = '0;
            m_vld = 1'b0;
        end else begin
            if (ir) begin
                if (sz > 0) begin
                    m_ir  = mq.pop_front();
                    m_vld = 1'b1;
                end else begin
                    m_vld = 1'b0;
                end
            end
            if (v && sz < DEPTH) mq.push_back(w);
        end
    endtask

    task automatic step(input string tag, input logic v, input logic [31:0] w,
                        input logic ir, input logic f);
        @(negedge Clock);
        in_valid = v; in_instr = w; IRin = ir; flush = f;
        @(posedge Clock);
        #1;
        model_update(v, w, ir, f);
        in_valid = 1'b0; IRin = 1'b0; flush = 1'b0;
        check_model(tag);
    endtask

    task automatic model_reset();
        mq.delete();
        m_ir  = '0;
        m_vld = 1'b0;
    endtask

    vec_t vecs[9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // opc, ra, rb, rc, c2, c, jaddr, fmt, ill
        vecs[0] = '{32'h19980000, '{5'd3,  4'd3, 4'd3, 4'd0, 4'd0, 32'h0,        23'h0,      3'd1, 1'b0}};
        vecs[1] = '{32'h61980000, '{5'd12, 4'd3, 4'd3, 4'd0, 4'd0, 32'h0,        23'h0,      3'd2, 1'b0}};
        vecs[2] = '{32'h9A87FFFF, '{5'd19, 4'd5, 4'd0, 4'd0, 4'd0, 32'hFFFFFFFF, 23'h0,      3'd4, 1'b0}};
        vecs[3] = '{32'hF0000000, '{5'd30, 4'd0, 4'd0, 4'd0, 4'd0, 32'h0,        23'h0,      3'd7, 1'b1}};
        vecs[4] = '{32'hAB923456, '{5'd21, 4'd7, 4'd0, 4'd0, 4'd0, 32'h0,        23'h123456, 3'd5, 1'b0}};
        vecs[5] = '{32'h00940000, '{5'd0,  4'd1, 4'd2, 4'd0, 4'd0, 32'hFFFC0000, 23'h0,      3'd0, 1'b0}};
        vecs[6] = '{32'h79207FFF, '{5'd15, 4'd2, 4'd4, 4'd0, 4'd0, 32'h0,        23'h0,      3'd3, 1'b0}};
        vecs[7] = '{32'hB4F80000, '{5'd22, 4'd9, 4'd0, 4'd0, 4'd0, 32'h0,        23'h0,      3'd6, 1'b0}};
        vecs[8] = '{32'hDFFFFFFF, '{5'd27, 4'd0, 4'd0, 4'd0, 4'd0, 32'h0,        23'h0,      3'd7, 1'b0}};

        repeat (2) @(posedge Clock);
        #1;
        check("reset.count", 64'(count), 64'd0);
        check("reset.ir_valid", 64'(ir_valid), 64'd0);
        check("reset.IR", 64'(IR), 64'd0);
        @(negedge Clock);
        Clear = 1'b0;
        #1;
        check("reset.in_ready", 64'(in_ready), 64'd1);

        // Decode table: push, then IRin two edges later
        for (int i = 0; i < 9; i++) begin
            step($sformatf("vec%0d.push", i), 1'b1, vecs[i].instr, 1'b0, 1'b0);
            step($sformatf("vec%0d.irin", i), 1'b0, 32'h0, 1'b1, 1'b0);
            check($sformatf("vec%0d.IR", i), 64'(IR), 64'(vecs[i].instr));
            check_dec($sformatf("vec%0d", i), vecs[i].exp);
        end

        // IRin on empty queue drops ir_valid, IR keeps the old word
        step("empty_irin", 1'b0, 32'h0, 1'b1, 1'b0);
        check("empty_irin.IR_held", 64'(IR), 64'(vecs[8].instr));
        check("empty_irin.fmt", 64'(fmt), 64'd0);

        // Fill to DEPTH, 5th rejected, then drain in order
        for (int i = 0; i < 5; i++)
            step($sformatf("fill%0d", i), 1'b1, 32'h1000_0000 + 32'(i), 1'b0, 1'b0);
        check("full.count", 64'(count), 64'd4);
        check("full.in_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            step($sformatf("drain%0d", i), 1'b0, 32'h0, 1'b1, 1'b0);
            check($sformatf("drain%0d.word", i), 64'(IR), 64'(32'h1000_0000 + 32'(i)));
        end
        check("drained.count", 64'(count), 64'd0);

        // Full queue with push and pop in the same cycle: pop only
        for (int i = 0; i < 4; i++)
            step($sformatf("refill%0d", i), 1'b1, 32'h2000_0000 + 32'(i), 1'b0, 1'b0);
        step("full_pushpop", 1'b1, 32'h2AAA_AAAA, 1'b1, 1'b0);
        check("full_pushpop.count", 64'(count), 64'd3);
        check("full_pushpop.IR", 64'(IR), 64'h2000_0000);
        step("after_full_push", 1'b1, 32'h2BBB_BBBB, 1'b0, 1'b0);
        check("after_full_push.count", 64'(count), 64'd4);

        // Flush beats push and IRin
        step("flush_all", 1'b1, 32'h3CCC_CCCC, 1'b1, 1'b1);
        check("flush.count", 64'(count), 64'd0);
        check("flush.ir_valid", 64'(ir_valid), 64'd0);
        check("flush.IR", 64'(IR), 64'd0);
        step("ill.push", 1'b1, 32'hF5555555, 1'b0, 1'b0);
        step("ill.irin", 1'b0, 32'h0, 1'b1, 1'b0);
        check("ill.illegal", 64'(illegal), 64'd1);
        check("ill.Ra", 64'(Ra), 64'd0);
        check("ill.C", 64'(C), 64'd0);

        // Asynchronous Clear with three words queued and a live IR
        for (int i = 0; i < 3; i++)
            step($sformatf("pre_clr%0d", i), 1'b1, 32'h4000_0000 + 32'(i), 1'b0, 1'b0);
        check("pre_clr.count", 64'(count), 64'd3);
        @(negedge Clock);
        #2;
        Clear = 1'b1;
        #1;
        check("clr.count", 64'(count), 64'd0);
        check("clr.ir_valid", 64'(ir_valid), 64'd0);
        check("clr.IR", 64'(IR), 64'd0);
        model_reset();
        @(negedge Clock);
        Clear = 1'b0;
        #1;
        check("clr.in_ready", 64'(in_ready), 64'd1);
        step("post_clr", 1'b0, 32'h0, 1'b1, 1'b0);

        // Random traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            logic v, ir, f;
            logic [31:0] w;
            v  = ($urandom_range(0, 99) < 60);
            ir = ($urandom_range(0, 99) < 45);
            f  = ($urandom_range(0, 99) < 4);
            w  = $urandom;
            step($sformatf("rnd%0d", i), v, w, ir, f);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
